// File: rtl/cpt_cascade_hi_if.sv
// Bus between the upper-count cascade stage and its controller: run control,
// lower-counter value, load/compare inputs and the status outputs.
interface cpt_cascade_hi_if #(
    parameter int HI_W = 5
);
    logic              start;
    logic              stop;
    logic [2:0]        cpt_lo;
    logic              load;
    logic [HI_W-1:0]   load_val;
    logic [HI_W+2:0]   match_val;
    logic              activate;
    logic [HI_W-1:0]   cpt_hi;
    logic              match;
    logic              ovf;
    logic              running;

    modport master (
        output start, stop, cpt_lo, load, load_val, match_val,
        input  activate, cpt_hi, match, ovf, running
    );

    modport slave (
        input  start, stop, cpt_lo, load, load_val, match_val,
        output activate, cpt_hi, match, ovf, running
    );
endinterface

// File: rtl/cpt_cascade_hi.sv
// Upper-order extension of a 3-bit lower counter: carries into an HI_W-bit
// upper count and owns the shared activate enable through a run-control FSM.
module cpt_cascade_hi #(
    parameter int HI_W          = 5,
    parameter bit STOP_ON_MATCH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    cpt_cascade_hi_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [HI_W-1:0] HI_ONES = {HI_W{1'b1}};
    localparam logic [HI_W-1:0] HI_ONE  = HI_W'(1'b1);

    state_e          state_q, state_d;
    logic [HI_W-1:0] cpt_hi_q, cpt_hi_d;
    logic            match_q, match_d;
    logic            ovf_q, ovf_d;
    logic            activate_s;
    logic            carry_s;
    logic            hit_s;

    // activate is a pure decode of the registered state, so it is glitch-free
    assign activate_s = (state_q == RUN);
    assign carry_s    = activate_s & (bus.cpt_lo == 3'd7);
    assign hit_s      = activate_s & ({cpt_hi_q, bus.cpt_lo} == bus.match_val);

    // Run-control next state; stop dominates start everywhere
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) state_d = RUN;
                else                        state_d = IDLE;
            end
            RUN: begin
                if (bus.stop)                         state_d = HALT;
                else if (STOP_ON_MATCH && hit_s)      state_d = HALT;
                else                                  state_d = RUN;
            end
            HALT: begin
                if (bus.start && !bus.stop) state_d = RUN;
                else                        state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Upper count, sticky wrap flag and compare pulse; load beats carry
    always_comb begin
        cpt_hi_d = cpt_hi_q;
        ovf_d    = ovf_q;
        match_d  = hit_s;
        if (bus.load) begin
            cpt_hi_d = bus.load_val;
        end else if (carry_s) begin
            cpt_hi_d = cpt_hi_q + HI_ONE;
            if (cpt_hi_q == HI_ONES) ovf_d = 1'b1;
            else                     ovf_d = ovf_q;
        end else begin
            cpt_hi_d = cpt_hi_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cpt_hi_q <= '0;
            match_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpt_hi_q <= cpt_hi_d;
            match_q  <= match_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.activate = activate_s;
    assign bus.running  = activate_s;
    assign bus.cpt_hi   = cpt_hi_q;
    assign bus.match    = match_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_cpt_cascade_hi.sv
// Bench for cpt_cascade_hi: two instances (match only / stop on match), each
// paired with a behavioural model of the 3-bit lower counter.
module tb_cpt_cascade_hi;
    localparam int HI_W = 5;

    typedef struct {
        logic       rst, st, sp, ld;
        logic [4:0] ldv;
        logic [4:0] e_hi;
        logic [2:0] e_lo;
        logic       e_act, e_match, e_ovf;
    } vec_t;

    typedef struct {
        logic [4:0] hi;
        logic [2:0] lo;
        logic       act, match, ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, load;
    logic [4:0] load_val;
    logic [2:0] lo_a, lo_b;
    int         total = 0;
    int         bad   = 0;
    exp_t       exp_q[$];
    vec_t       vecs[12];

    cpt_cascade_hi_if #(.HI_W(HI_W)) if_a ();
    cpt_cascade_hi_if #(.HI_W(HI_W)) if_b ();

    cpt_cascade_hi #(.HI_W(HI_W), .STOP_ON_MATCH(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    cpt_cascade_hi #(.HI_W(HI_W), .STOP_ON_MATCH(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));

    always #5 clk = ~clk;

    // Lower bit_cpt3 models: increment when enabled, wrap 7->0, shared reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_a <= 3'd0;
            lo_b <= 3'd0;
        end else begin
            if (if_a.activate) lo_a <= lo_a + 3'd1;
            if (if_b.activate) lo_b <= lo_b + 3'd1;
        end
    end

    assign if_a.start = start;      assign if_b.start = start;
    assign if_a.stop = stop;        assign if_b.stop = stop;
    assign if_a.load = load;        assign if_b.load = load;
    assign if_a.load_val = load_val; assign if_b.load_val = load_val;
    assign if_a.cpt_lo = lo_a;      assign if_b.cpt_lo = lo_b;
    assign if_a.match_val = 8'd255; assign if_b.match_val = 8'd20;

    wire [7:0] full_a = {if_a.cpt_hi, lo_a};
    wire [7:0] full_b = {if_b.cpt_hi, lo_b};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic p,
                        input logic l, input logic [4:0] lv);
        reset = r; start = s; stop = p; load = l; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        exp_t e;
        int   n;
        int   pulses;
        int   drops;
        logic [7:0] pre;

        reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; load_val = 5'd0;

        // Reset, start, then count through the first carry into cpt_hi
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 2; i <= 9; i++) begin
            vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                        (i == 9) ? 5'd1 : 5'd0, 3'((i - 1) % 8), 1'b1, 1'b0, 1'b0};
        end
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 3'd2, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            exp_q.push_back('{vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_act,
                              vecs[i].e_match, vecs[i].e_ovf});
            step(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].ld, vecs[i].ldv);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_hi", i), if_a.cpt_hi, e.hi);
            chk($sformatf("vec%0d_lo", i), lo_a, e.lo);
            chk($sformatf("vec%0d_act", i), if_a.activate, e.act);
            chk($sformatf("vec%0d_run", i), if_a.running, e.act);
            chk($sformatf("vec%0d_match", i), if_a.match, e.match);
            chk($sformatf("vec%0d_ovf", i), if_a.ovf, e.ovf);
        end

        // Run to full count 255, wrap, then two more laps
        n = 0;
        while (full_a != 8'd255 && n < 400) begin step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0); n++; end
        chk("t2_reach255", full_a, 8'd255);
        chk("t2_ovf_pre", if_a.ovf, 1'b0);
        chk("t2_match_pre", if_a.match, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t2_wrap_hi", if_a.cpt_hi, 5'd0);
        chk("t2_wrap_lo", lo_a, 3'd0);
        chk("t2_wrap_ovf", if_a.ovf, 1'b1);
        chk("t2_wrap_match", if_a.match, 1'b1);
        pulses = 0; drops = 0;
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
            if (if_a.match === 1'b1) pulses++;
            if (if_a.ovf !== 1'b1) drops++;
        end
        chk("t2_pulses", pulses, 2);
        chk("t2_ovf_drops", drops, 0);
        chk("t2_lap_count", full_a, 8'd0);

        // Load coinciding with a carry wins; then count through the wrap
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        n = 0;
        while (lo_a != 3'd7 && n < 20) begin step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0); n++; end
        chk("t4_lo7", lo_a, 3'd7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd30);
        chk("t4_load_hi", if_a.cpt_hi, 5'd30);
        chk("t4_load_lo", lo_a, 3'd0);
        chk("t4_load_ovf", if_a.ovf, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t4_hi31", if_a.cpt_hi, 5'd31);
        chk("t4_ovf31", if_a.ovf, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t4_hi0", if_a.cpt_hi, 5'd0);
        chk("t4_ovf_wrap", if_a.ovf, 1'b1);

        // Reset mid-run at cpt_hi=17
        n = 0;
        while (if_a.cpt_hi != 5'd17 && n < 300) begin step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0); n++; end
        chk("t6_hi17", if_a.cpt_hi, 5'd17);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t6_rst_hi", if_a.cpt_hi, 5'd0);
        chk("t6_rst_lo", lo_a, 3'd0);
        chk("t6_rst_ovf", if_a.ovf, 1'b0);
        chk("t6_rst_match", if_a.match, 1'b0);
        chk("t6_rst_act", if_a.activate, 1'b0);
        chk("t6_rst_run", if_a.running, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t6_idle_count", full_a, 8'd0);
        chk("t6_idle_act", if_a.activate, 1'b0);

        // start+stop together in RUN halts; start alone resumes
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("t5_run", if_a.activate, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        pre = full_a;
        chk("t5_pre", pre, 8'd10);
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
        chk("t5_halt_act", if_a.activate, 1'b0);
        chk("t5_halt_count", full_a, 8'd11);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t5_frozen", full_a, 8'd11);
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
        chk("t5_halt_both", if_a.activate, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("t5_resume_act", if_a.activate, 1'b1);
        chk("t5_resume_count", full_a, 8'd11);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t5_resume_inc", full_a, 8'd12);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("t5_stop_act", if_a.activate, 1'b0);
        chk("t5_stop_count", full_a, 8'd13);

        // Stop-on-match instance halts at match_val=20 and settles at 21
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        n = 0;
        while (if_b.running === 1'b1 && n < 60) begin step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0); n++; end
        chk("t3_halted", if_b.running, 1'b0);
        chk("t3_match", if_b.match, 1'b1);
        chk("t3_act", if_b.activate, 1'b0);
        chk("t3_count", full_b, 8'd21);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t3_match_clr", if_b.match, 1'b0);
        chk("t3_frozen", full_b, 8'd21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpt_cascade_hi.md
Name: cpt_cascade_hi

Overview:
- Upper-order extension stage that sits directly downstream of the 3-bit counter `bit_cpt3`.
- Consumes the lower counter's `cpt` value and the same `activate` enable, and carries into an HI_W-bit upper count, forming a (HI_W+3)-bit counter.
- Adds a run-control FSM that drives the shared `activate` enable, a compare-match stop, and a sticky overflow flag.
- Lets a 3-bit lower counter be reused for wide timing without modifying it.

Parameters:
- HI_W, 5, width of the upper count (full count width is HI_W+3).
- STOP_ON_MATCH, 1, 1 = FSM stops counting when the full count equals match_val; 0 = match only flags.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high; shared with the lower counter.
- start  input  1  request to begin or resume counting.
- stop  input  1  request to halt counting.
- cpt_lo  input  3  current count from the lower `bit_cpt3`.
- load  input  1  load load_val into the upper count.
- load_val  input  HI_W  value loaded into cpt_hi.
- match_val  input  HI_W+3  compare target for the full count {cpt_hi, cpt_lo}.
- activate  output  1  enable driven to the lower counter; high only in RUN.
- cpt_hi  output  HI_W  upper count.
- match  output  1  one-cycle registered pulse on compare hit.
- ovf  output  1  sticky full-count wrap flag.
- running  output  1  high in RUN state.

Behaviour:
- Reset (sampled at posedge clk while reset=1): state=IDLE, cpt_hi=0, activate=0, match=0, ovf=0, running=0. Reset overrides every other input.
- Lower-counter contract: `bit_cpt3` increments at a posedge when activate=1 and wraps 7->0.
- Carry term: carry = activate & (cpt_lo==7), combinational and internal only.
- Upper-count update, by priority at each posedge:
  - reset
  - load: cpt_hi<=load_val, ovf unchanged; load wins over carry in the same cycle.
  - carry: cpt_hi<=cpt_hi+1, modulo 2^HI_W.
- Full wrap: carry while cpt_hi all-ones -> cpt_hi<=0 and ovf<=1. ovf clears only on reset.
- Compare: hit = activate & ({cpt_hi,cpt_lo}==match_val), evaluated before the edge. match<=hit, so match is high for exactly one cycle after the edge at which the matching value was present and active. No hit is evaluated outside RUN.
- FSM states: IDLE, RUN, HALT.
  - IDLE: start=1 -> RUN.
  - RUN: stop=1 -> HALT. Otherwise, if STOP_ON_MATCH=1 and hit=1 -> HALT.
  - HALT: start=1 & stop=0 -> RUN.
  - start and stop both high: stop wins in RUN; in IDLE and HALT the state does not move.
- activate is decoded from the registered state: activate=running=(state==RUN).
- First increment latency: start sampled at edge N -> activate high after edge N -> the lower counter increments at edge N+1.
- Stop on match: the edge that sees the hit still increments the lower counter, since activate was high. Counting freezes from the next cycle, so the count settles at match_val+1.
- Stop input: the edge that samples stop also increments, so the count freezes one past its value at that edge.
- Reset mid-count: all state is cleared at that edge; the lower counter clears via the shared reset. No match pulse and no ovf are produced by a reset.
- load while RUN is allowed; the upper count is replaced, and the lower count continues.
- match_val above the reachable range never hits.

Test Plan:
1. Reset, then start=1 for one cycle, with HI_W=5 and match_val=255 -> activate rises one cycle after start. cpt_hi steps 0->1 at the edge where cpt_lo goes 7->0 (9th edge after start).
2. Let the count run to full 255 with STOP_ON_MATCH=0 -> at the next carry cpt_hi wraps 31->0, ovf=1 and stays 1 after further wraps. match pulses once per 256 active cycles.
3. STOP_ON_MATCH=1, match_val=8'd20 (cpt_hi=2, cpt_lo=4) -> match=1 for one cycle. running and activate go to 0 in the same cycle, and the count freezes at 21.
4. In RUN, load=1 with load_val=5'd30 at the same edge as a carry -> cpt_hi=30 (load priority). The next carry gives 31, the following one gives 0 with ovf=1.
5. start=1 and stop=1 together in RUN -> HALT, activate=0. Then start alone -> RUN, and the count resumes from the frozen value.
6. reset=1 mid-run at cpt_hi=17 -> after the edge cpt_hi=0, ovf=0, match=0, state IDLE, activate=0. With start held at 0, the count stays 0.
